pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter / next-PC generator at the head of the fetch stage.
//  Produces fetch addresses toward instruction memory under a valid/ready handshake.
//  Arbitrates trap, redirect (branch/jump from execute), stall and sequential advance.
//  Flags misaligned redirect targets and optionally predicts taken branches with a direct-mapped BTB.
// PARAMETERS
//  XLEN          32  address width in bits
//  RESET_VECTOR  0   fetch_pc value after reset; must be 4-byte aligned
//  BTB_ENTRIES   16  BTB depth, power of 2, >=2; used only with PC_BTB_EN
// PORTS
//  clk               in   1     clock, all state on rising edge
//  rst               in   1     asynchronous, active-high reset
//  stall             in   1     hold PC: pipeline cannot accept a new instruction
//  redirect_valid    in   1     execute resolved a taken branch/jump or misprediction
//  redirect_pc       in   XLEN  redirect target
//  trap_valid        in   1     trap/exception entry request
//  trap_pc           in   XLEN  trap handler address; must be aligned
//  fetch_valid       out  1     fetch_pc is a valid request
//  fetch_ready       in   1     instruction memory accepts the request this cycle
//  fetch_pc          out  XLEN  current fetch address
//  fetch_pred_taken  out  1     BTB hit: the next PC after fetch_pc is a predicted target
//  misalign          out  1     redirect target misaligned; fetch halted
//  btb_upd_valid     in   1     write BTB entry (taken branch resolved)
//  btb_upd_pc        in   XLEN  branch address
//  btb_upd_target    in   XLEN  branch target
// BEHAVIOUR
//  - Reset (async assert): fetch_pc=RESET_VECTOR, fetch_valid=0, misalign=0,
//    fetch_pred_taken=0, state=BOOT, all BTB valid bits cleared.
//  - FSM BOOT -> RUN on the first clock edge after rst deasserts (one bubble cycle).
//    RUN -> FAULT on a misaligned redirect. FAULT -> RUN only on trap_valid.
//  - fetch_valid=1 in RUN only. It is 0 in BOOT and FAULT.
//  - Per-edge priority in RUN:
//    trap_valid > redirect_valid > stall > accept (fetch_valid & fetch_ready) > hold.
//    * trap: fetch_pc<=trap_pc. Valid in any state, including FAULT; clears misalign.
//    * redirect, redirect_pc[1:0]==0: fetch_pc<=redirect_pc.
//    * redirect, redirect_pc[1:0]!=0: fetch_pc<=redirect_pc, misalign<=1, state<=FAULT.
//    * redirect is ignored in BOOT and FAULT.
//    * redirect/trap take effect regardless of fetch_ready. The pending request is dropped.
//    * stall: fetch_pc and fetch_valid hold.
//    * accept: fetch_pc <= BTB-hit ? predicted target : fetch_pc+4.
//    * valid & !ready: fetch_pc held stable, no advance.
//  - Handshake: while fetch_valid=1 and fetch_ready=0, fetch_pc must not change unless trap/redirect.
//  - Arithmetic is modulo 2^XLEN: fetch_pc=2^XLEN-4 advances to 0, with no flag.
//  - Redirect latency: 1 cycle. The target appears on fetch_pc after the edge sampling redirect_valid.
//  - Reset mid-operation: immediate return to the reset values above. The BTB is cleared.
// CONFIGURATION
//  PC_BTB_EN defined:
//    - BTB is direct-mapped. Index = pc[log2(BTB_ENTRIES)+1:2]; tag = remaining upper bits; one valid bit per entry.
//    - Lookup is combinational on fetch_pc. fetch_pred_taken = valid & tag match & fetch_valid.
//    - btb_upd_valid writes index/tag/target and sets valid. The write is visible to lookups from the next cycle.
//    - An update and a lookup on the same index in the same cycle: the lookup sees the old entry.
//  PC_BTB_EN undefined:
//    - No BTB storage. fetch_pred_taken is tied 0; btb_upd_* are ignored.
//    - Accept always advances by +4.
// TESTING
//  1 Reset, RESET_VECTOR=0x100, fetch_ready=1 -> one bubble, then fetch_pc 0x100,0x104,0x108 with fetch_valid=1.
//  2 fetch_ready=0 for 3 cycles at pc 0x20 -> fetch_pc stays 0x20, fetch_valid=1; ready=1 -> 0x24 next.
//  3 Same cycle: stall=1, redirect_valid=1 (0x400), trap_valid=1 (0x80) -> next fetch_pc=0x80.
//    Then redirect to 0x402 -> misalign=1, fetch_valid=0. Then trap to 0x80 -> RUN, misalign=0.
//  4 fetch_pc=0xFFFFFFFC accepted -> next fetch_pc=0x0, fetch_valid=1.
//  5 (PC_BTB_EN) btb_upd 0x40->0x200. Fetch 0x40 -> fetch_pred_taken=1, next fetch_pc=0x200.
//    Then fetch 0x40+4*BTB_ENTRIES (aliasing index, tag mismatch) -> fetch_pred_taken=0, +4.
//  6 Assert rst asynchronously mid-stream at pc 0x88 -> outputs reset immediately.
//    (PC_BTB_EN) The former hit at 0x40 now misses.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program counter: trap/redirect/stall/advance arbitration with a valid/ready fetch port.
// Optional direct-mapped BTB branch prediction when PC_BTB_EN is defined.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_pred_taken,
  output logic            misalign,
  input  logic            btb_upd_valid,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Elaboration-time parameter sanity checks
  if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_btb_entries
    $error("pc_gen: BTB_ENTRIES must be a power of two and >= 2");
  end
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("pc_gen: RESET_VECTOR must be 4-byte aligned");
  end

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_d;
  logic            misalign_d;
  logic            fetch_valid_d;
  logic            btb_hit;
  logic [XLEN-1:0] pred_target;

`ifdef PC_BTB_EN
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
  logic [IDX_W-1:0]       lk_idx, upd_idx;
  logic [TAG_W-1:0]       lk_tag, upd_tag;
  logic                   unused_lsb;

  assign lk_idx     = fetch_pc[IDX_W+1:2];
  assign lk_tag     = fetch_pc[XLEN-1:IDX_W+2];
  assign upd_idx    = btb_upd_pc[IDX_W+1:2];
  assign upd_tag    = btb_upd_pc[XLEN-1:IDX_W+2];
  assign unused_lsb = ^{fetch_pc[1:0], btb_upd_pc[1:0]};

  // Valid bits are the only BTB state that must clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (btb_upd_valid) begin
      btb_valid[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_upd_valid) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= btb_upd_target;
    end
  end

  // Lookup reads pre-edge contents, so a same-cycle update is not yet visible
  assign btb_hit          = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign pred_target      = btb_target[lk_idx];
  assign fetch_pred_taken = btb_hit && fetch_valid;
`else
  logic unused_btb_upd;

  assign unused_btb_upd   = ^{btb_upd_valid, btb_upd_pc, btb_upd_target};
  assign btb_hit          = 1'b0;
  assign pred_target      = '0;
  assign fetch_pred_taken = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      fetch_pc    <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc    <= pc_d;
      fetch_valid <= fetch_valid_d;
      misalign    <= misalign_d;
    end
  end

  // Next-PC arbitration: trap > redirect > stall > accept > hold
  always_comb begin
    state_d    = state_q;
    pc_d       = fetch_pc;
    misalign_d = misalign;

    if (trap_valid) begin
      pc_d       = trap_pc;
      misalign_d = 1'b0;
      state_d    = ST_RUN;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (redirect_valid) begin
            pc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
              misalign_d = 1'b1;
              state_d    = ST_FAULT;
            end
          end else if (stall) begin
            pc_d = fetch_pc;
          end else if (fetch_valid && fetch_ready) begin
            pc_d = btb_hit ? pred_target : fetch_pc + XLEN'(4);
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_BOOT;
      endcase
    end

    fetch_valid_d = (state_d == ST_RUN);
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver queues expected fetch transactions, a monitor checks handshakes.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RV = 32'h0000_0100;
  localparam int unsigned BTB_N = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall, redirect_valid, trap_valid, fetch_ready, btb_upd_valid;
  logic [XLEN-1:0] redirect_pc, trap_pc, btb_upd_pc, btb_upd_target;
  logic            fetch_valid, fetch_pred_taken, misalign;
  logic [XLEN-1:0] fetch_pc;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .BTB_ENTRIES(BTB_N)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_pred_taken(fetch_pred_taken), .misalign(misalign),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc), .btb_upd_target(btb_upd_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic pred);
    exp_t e;
    e.pc   = pc;
    e.pred = pred;
    sb.push_back(e);
  endtask

  task automatic do_trap(input logic [XLEN-1:0] pc);
    trap_valid = 1'b1;
    trap_pc    = pc;
    cycle();
    trap_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
    chk(name, XLEN'(sb.size()), '0);
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_pc"}, fetch_pc, RV);
    chk({tag, "_valid"}, XLEN'(fetch_valid), '0);
    chk({tag, "_misalign"}, XLEN'(misalign), '0);
    chk({tag, "_pred"}, XLEN'(fetch_pred_taken), '0);
  endtask

  // Monitor: every accepted fetch must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fetch_valid && fetch_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_handshake", fetch_pc, '1);
        end else begin
          e = sb.pop_front();
          chk("hs_pc", fetch_pc, e.pc);
          chk("hs_pred", XLEN'(fetch_pred_taken), XLEN'(e.pred));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0; fetch_ready = 1'b0;
    btb_upd_valid = 1'b0; redirect_pc = '0; trap_pc = '0; btb_upd_pc = '0; btb_upd_target = '0;
    repeat (3) cycle();
    chk_idle_reset("reset");

    // Boot: one bubble, then sequential fetch from the reset vector
    push(32'h100, 1'b0); push(32'h104, 1'b0); push(32'h108, 1'b0);
    fetch_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("boot_bubble", XLEN'(fetch_valid), '0);
    repeat (4) cycle();
    fetch_ready = 1'b0;
    drain("drain_boot");
    chk("boot_pc_after", fetch_pc, 32'h10C);

    // Back-pressure: pc held while not ready
    do_trap(32'h20);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_pc", fetch_pc, 32'h20);
      chk("bp_valid", XLEN'(fetch_valid), 32'h1);
    end
    push(32'h20, 1'b0);
    fetch_ready = 1'b1;
    cycle();
    fetch_ready = 1'b0;
    chk("bp_release_pc", fetch_pc, 32'h24);
    drain("drain_bp");

    // Priority: trap beats redirect and stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400; trap_valid = 1'b1; trap_pc = 32'h80;
    cycle();
    stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
    chk("prio_pc", fetch_pc, 32'h80);
    chk("prio_valid", XLEN'(fetch_valid), 32'h1);

    // Stall holds pc even while memory is ready
    push(32'h80, 1'b0); push(32'h80, 1'b0);
    stall = 1'b1; fetch_ready = 1'b1;
    repeat (2) cycle();
    chk("stall_pc", fetch_pc, 32'h80);
    push(32'h80, 1'b0); push(32'h84, 1'b0);
    stall = 1'b0;
    repeat (2) cycle();
    fetch_ready = 1'b0;
    chk("unstall_pc", fetch_pc, 32'h88);
    drain("drain_stall");

    // Aligned redirect, 1-cycle latency
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    cycle();
    redirect_valid = 1'b0;
    chk("redir_pc", fetch_pc, 32'h300);
    chk("redir_misalign", XLEN'(misalign), '0);

    // Misaligned redirect enters FAULT; further redirects ignored; trap recovers
    redirect_valid = 1'b1; redirect_pc = 32'h402;
    cycle();
    chk("mis_flag", XLEN'(misalign), 32'h1);
    chk("mis_valid", XLEN'(fetch_valid), '0);
    chk("mis_pc", fetch_pc, 32'h402);
    redirect_pc = 32'h500; fetch_ready = 1'b1;
    cycle();
    redirect_valid = 1'b0; fetch_ready = 1'b0;
    chk("fault_ignore_pc", fetch_pc, 32'h402);
    chk("fault_ignore_valid", XLEN'(fetch_valid), '0);
    do_trap(32'h80);
    chk("recover_misalign", XLEN'(misalign), '0);
    chk("recover_valid", XLEN'(fetch_valid), 32'h1);
    chk("recover_pc", fetch_pc, 32'h80);

    // Wrap-around at the top of the address space
    do_trap(32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 1'b0); push(32'h0, 1'b0);
    fetch_ready = 1'b1;
    repeat (2) cycle();
    fetch_ready = 1'b0;
    chk("wrap_pc", fetch_pc, 32'h4);
    chk("wrap_valid", XLEN'(fetch_valid), 32'h1);
    drain("drain_wrap");

`ifdef PC_BTB_EN
    // BTB hit, then aliasing index with different tag
    btb_upd_valid = 1'b1; btb_upd_pc = 32'h40; btb_upd_target = 32'h200;
    cycle();
    btb_upd_valid = 1'b0;
    do_trap(32'h40);
    push(32'h40, 1'b1); push(32'h200, 1'b0);
    fetch_ready = 1'b1;
    repeat (2) cycle();
    fetch_ready = 1'b0;
    chk("btb_hit_next_pc", fetch_pc, 32'h204);
    do_trap(32'h40 + 4 * BTB_N);
    push(32'h40 + 4 * BTB_N, 1'b0); push(32'h44 + 4 * BTB_N, 1'b0);
    fetch_ready = 1'b1;
    repeat (2) cycle();
    fetch_ready = 1'b0;
    chk("btb_alias_pc", fetch_pc, 32'h48 + 4 * BTB_N);
    drain("drain_btb");
`endif

    // Asynchronous reset mid-stream
    do_trap(32'h88);
    fetch_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_idle_reset("async_rst");
    fetch_ready = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_rst_pc", fetch_pc, RV);
    chk("post_rst_valid", XLEN'(fetch_valid), 32'h1);

`ifdef PC_BTB_EN
    do_trap(32'h40);
    push(32'h40, 1'b0); push(32'h44, 1'b0);
    fetch_ready = 1'b1;
    repeat (2) cycle();
    fetch_ready = 1'b0;
    chk("btb_cleared_pc", fetch_pc, 32'h48);
`endif
    drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
